// File: rtl/irq_ctrl_defs.sv
// Shared definitions for the interrupt controller: register map, source count,
// HWInt mapping and the in-service state type.
package irq_ctrl_defs;

    localparam int N_SRC     = 6;
    localparam int ID_W      = 3;
    localparam int HWINT_W   = 6;
    localparam int HWINT_LSB = 2;  // source i drives HWInt[i + HWINT_LSB] at the CPU

    localparam logic [31:0] BASE_ADDR = 32'h0000_7F60;

    localparam logic [1:0] REG_MODE = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_PEND = 2'd2;
    localparam logic [1:0] REG_CUR  = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } svc_state_e;

    function automatic logic [N_SRC-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_SRC-1:0] one;
        one = {{(N_SRC-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request.
module irq_prio_enc
    import irq_ctrl_defs::*;
(
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller: edge/level latching, masking, fixed
// priority selection and single-level in-service tracking released by EOI.
//
// state     | meaning
// ST_IDLE   | nothing in service, accepts the highest-priority unmasked pending source
// ST_ACTIVE | one source in service on HWInt until a CUR write (EOI)
module irq_controller
    import irq_ctrl_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         addr,
    input  logic [31:0]        wd,
    input  logic               we,
    output logic [31:0]        rd,
    input  logic [N_SRC-1:0]   irq_src,
    output logic [HWINT_W-1:0] HWInt
);

    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] src_d;
    logic [ID_W-1:0]  id;
    svc_state_e       state;

    logic             wr_mode;
    logic             wr_mask;
    logic             wr_pend;
    logic             wr_cur;
    logic             eoi;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] mode_nxt;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] edge_nxt;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] cand;
    logic             cand_valid;
    logic [ID_W-1:0]  cand_id;
    logic             unused_wd;

    assign unused_wd = ^wd[31:N_SRC];

    assign wr_mode = we && (addr == REG_MODE);
    assign wr_mask = we && (addr == REG_MASK);
    assign wr_pend = we && (addr == REG_PEND);
    assign wr_cur  = we && (addr == REG_CUR);
    assign eoi     = wr_cur && (state == ST_ACTIVE);

    assign rise     = irq_src & ~src_d;
    assign mode_nxt = wr_mode ? wd[N_SRC-1:0] : mode;

    // Clears are applied before the new edge is OR-ed in, so a coincident edge wins.
    assign clr      = (wr_pend ? wd[N_SRC-1:0] : '0) | (eoi ? id_to_onehot(id) : '0);
    assign edge_nxt = (pend & ~clr) | rise;

    // Using the post-write mode lets a level->edge switch hold its current pending value.
    assign pend_nxt = (mode_nxt & edge_nxt) | (~mode_nxt & irq_src);

    assign cand = pend & mask;

    irq_prio_enc u_prio_enc (
        .req   (cand),
        .valid (cand_valid),
        .id    (cand_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode  <= '0;
            mask  <= '0;
            pend  <= '0;
            src_d <= '0;
            id    <= '0;
            state <= ST_IDLE;
            HWInt <= '0;
        end else begin
            src_d <= irq_src;
            pend  <= pend_nxt;
            mode  <= mode_nxt;
            if (wr_mask) begin
                mask <= wd[N_SRC-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (cand_valid) begin
                        state <= ST_ACTIVE;
                        id    <= cand_id;
                        HWInt <= id_to_onehot(cand_id);
                    end
                end
                ST_ACTIVE: begin
                    if (wr_cur) begin
                        state <= ST_IDLE;
                        HWInt <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    HWInt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            REG_MODE: rd[N_SRC-1:0] = mode;
            REG_MASK: rd[N_SRC-1:0] = mask;
            REG_PEND: rd[N_SRC-1:0] = pend;
            REG_CUR: begin
                rd[31]       = (state == ST_ACTIVE);
                rd[ID_W-1:0] = id;
            end
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a per-cycle behavioural model pushes the
// expected post-edge HWInt and read data; a monitor pops and compares.
module tb_irq_controller;
    import irq_ctrl_defs::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         addr = '0;
    logic [31:0]        wd = '0;
    logic               we = 1'b0;
    logic [31:0]        rd;
    logic [N_SRC-1:0]   irq_src = '0;
    logic [HWINT_W-1:0] HWInt;

    always #5 clk = ~clk;

    irq_controller dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wd      (wd),
        .we      (we),
        .rd      (rd),
        .irq_src (irq_src),
        .HWInt   (HWInt)
    );

    typedef struct {
        logic [5:0]  hw;
        logic [31:0] rdata;
        int          a;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit m_mode[N_SRC];
    bit m_mask[N_SRC];
    bit m_pend[N_SRC];
    bit m_prev[N_SRC];
    int m_svc  = -1;
    int m_last = 0;

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < N_SRC; i++) begin
            if (a == 0 && m_mode[i]) v = v + (32'd1 << i);
            if (a == 1 && m_mask[i]) v = v + (32'd1 << i);
            if (a == 2 && m_pend[i]) v = v + (32'd1 << i);
        end
        if (a == 3) v = (m_svc >= 0 ? 32'h8000_0000 : 32'h0) + 32'(m_last);
        return v;
    endfunction

    // Model of what one rising edge does, given the inputs presented before it.
    task automatic step(input bit r, input bit w, input int a, input logic [31:0] d,
                        input logic [5:0] s);
        int pick;
        bit eoi;
        bit nm;
        if (r) begin
            for (int i = 0; i < N_SRC; i++) begin
                m_mode[i] = 0; m_mask[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
            end
            m_svc  = -1;
            m_last = 0;
            return;
        end
        eoi  = w && a == 3 && m_svc >= 0;
        pick = -1;
        if (m_svc < 0) begin
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (m_pend[i] && m_mask[i]) pick = i;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            nm = (w && a == 0) ? d[i] : m_mode[i];
            if (!nm) begin
                m_pend[i] = s[i];
            end else begin
                if (w && a == 2 && d[i]) m_pend[i] = 0;
                if (eoi && m_svc == i) m_pend[i] = 0;
                if (s[i] && !m_prev[i]) m_pend[i] = 1;
            end
            m_mode[i] = nm;
            if (w && a == 1) m_mask[i] = d[i];
            m_prev[i] = s[i];
        end
        if (eoi) begin
            m_svc = -1;
        end else if (pick >= 0) begin
            m_svc  = pick;
            m_last = pick;
        end
    endtask

    task automatic cyc(input bit r, input bit w, input int a, input logic [31:0] d,
                       input logic [5:0] s);
        exp_t e;
        @(negedge clk);
        reset   = r;
        we      = w;
        addr    = a[1:0];
        wd      = d;
        irq_src = s;
        step(r, w, a, d, s);
        e.hw    = (m_svc >= 0) ? 6'(1 << m_svc) : 6'h00;
        e.rdata = m_read(a);
        e.a     = a;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (HWInt !== e.hw) begin
                    errors++;
                    $display("FAIL hwint t=%0t got %b expected %b", $time, HWInt, e.hw);
                end
                checks++;
                if (rd !== e.rdata) begin
                    errors++;
                    $display("FAIL rd[%0d] t=%0t got %h expected %h", e.a, $time, rd, e.rdata);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] bus_addr;
        logic [5:0]  s;
        bus_addr = BASE_ADDR + 32'h8;
        $display("irq_controller bench: base %h, PEND word %0d, HWInt lsb %0d",
                 BASE_ADDR, bus_addr[3:2], HWINT_LSB);

        // reset and read all registers
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) cyc(0, 0, a, 0, 0);

        // edge source 0 single pulse, delivery, EOI
        cyc(0, 1, 0, 32'h01, 0);
        cyc(0, 1, 1, 32'h01, 0);
        cyc(0, 0, 2, 0, 6'h01);
        cyc(0, 0, 2, 0, 6'h00);
        cyc(0, 0, 3, 0, 6'h00);
        cyc(0, 1, 3, 0, 6'h00);
        cyc(0, 0, 2, 0, 6'h00);
        cyc(0, 0, 3, 0, 6'h00);

        // level sources 1 and 4, priority and hand-over after EOI
        cyc(0, 1, 0, 32'h00, 0);
        cyc(0, 1, 1, 32'h3F, 0);
        repeat (3) cyc(0, 0, 3, 0, 6'h12);
        cyc(0, 1, 3, 0, 6'h10);
        repeat (3) cyc(0, 0, 3, 0, 6'h10);
        cyc(0, 1, 3, 0, 6'h10);
        cyc(0, 0, 3, 0, 6'h00);

        // masked edge source 2, W1C racing a new edge
        cyc(0, 1, 1, 32'h00, 0);
        cyc(0, 1, 0, 32'h04, 0);
        cyc(0, 0, 2, 0, 6'h04);
        cyc(0, 0, 2, 0, 6'h00);
        cyc(0, 1, 2, 32'h04, 6'h04);
        cyc(0, 0, 2, 0, 6'h00);
        cyc(0, 1, 2, 32'h04, 6'h00);
        cyc(0, 0, 2, 0, 6'h00);

        // source 3 in service survives masking, then reset mid-service
        cyc(0, 1, 2, 32'h3F, 0);
        cyc(0, 1, 0, 32'h00, 0);
        cyc(0, 1, 1, 32'h08, 0);
        repeat (3) cyc(0, 0, 3, 0, 6'h08);
        cyc(0, 1, 1, 32'h00, 6'h08);
        repeat (3) cyc(0, 0, 3, 0, 6'h08);
        cyc(1, 0, 3, 0, 6'h08);
        for (int a = 0; a < 4; a++) cyc(0, 0, a, 0, 6'h08);

        // randomized traffic
        s = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if ($urandom_range(0, 3) == 0) s[i] = ~s[i];
            end
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)), $urandom, s);
        end

        cyc(0, 0, 0, 0, s);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Programmable interrupt controller between the peripheral interrupt lines (timer, UART, switch, …) and the CPU's `HWInt[7:2]` inputs. Latches edge- or level-triggered requests, applies a software mask, selects one source by fixed priority and holds it in service until the CPU issues end-of-interrupt (EOI). Memory-mapped on the device bus at 0x0000_7F60–0x0000_7F6F, decoded by the bridge, which supplies a qualified write enable and word address.

## Interface

- `N_SRC`, 6, number of interrupt sources; source i drives `HWInt[i+2]`; source 0 is highest priority.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  2  register word select (device address bits [3:2]).
- `wd`  in  32  write data.
- `we`  in  1  write enable, already qualified by address hit.
- `rd`  out  32  read data, combinational from `addr` and current register state.
- `irq_src`  in  N_SRC  raw interrupt requests, synchronous to `clk`.
- `HWInt`  out  6  one-hot in-service source to the CPU (bits [7:2]); all zero when idle.

## Operation

- Registers (addr, by word):
  - 0 MODE: bits[N_SRC-1:0], 1 = rising-edge, 0 = level. R/W.
  - 1 MASK: bits[N_SRC-1:0], 1 = enabled. R/W.
  - 2 PEND: read pending vector. Write: write-1-to-clear on edge-mode bits; ignored for level bits.
  - 3 CUR: read {active, 28'b0, id[2:0]}. Any write = EOI.
  - Unused read bits are 0.
- Edge detect: `src_d` holds the previous cycle's `irq_src`. Edge pending bit sets when `irq_src & ~src_d`.
- Level pending bit is the registered `irq_src` value, updated every cycle.
- Acceptance: when idle, `cand = PEND & MASK`. If nonzero, the lowest-index set bit is loaded into the in-service id and `active` is set.
- `HWInt` is the one-hot decode of the in-service id, gated by `active`.
- EOI clears `active`. It also clears the in-service source's pending bit if that source is edge-mode.
- Only one source is in service at a time; there is no nesting.

## Timing

- Reset: MODE, MASK, PEND, `src_d` and `active` = 0; id = 0; `HWInt` = 0; `rd` reflects zeroed state.
- Latency:
  - `irq_src` rises, first sampled high at edge E: PEND bit set after E.
  - In service and `HWInt` asserted after E+1, provided the controller is idle and the bit is unmasked.
- EOI write at edge W: `HWInt` = 0 after W. The next acceptance can occur at W+1 at the earliest, so `HWInt` is low for at least 1 cycle between services.
- Boundary rules:
  - Set and W1C on the same bit at the same edge: set wins.
  - Set and EOI-clear on the same bit at the same edge: set wins.
  - MASK write and acceptance at the same edge: acceptance uses the old MASK.
  - A level source that drops while in service stays in service until EOI.
  - Masking the in-service source does not revoke it.
  - EOI while idle: no effect.
  - A source held high through reset records one edge (edge mode) on the first cycle after reset. It is pending but not delivered while masked.
  - Reset asserted mid-service returns the block to the idle reset state in the same edge.
- Writes to MODE: a bit switched from level to edge keeps its current pending value. Thereafter it changes only by edge, W1C or EOI.

## Structure

- Shared defs (`irq_ctrl_defs`):
  - register offsets MODE = 0, MASK = 1, PEND = 2, CUR = 3;
  - base address 32'h0000_7F60;
  - `N_SRC`;
  - HWInt bit mapping.
- Sub-module `irq_prio_enc`: combinational N_SRC → {valid, id[2:0]} lowest-index-first encoder.
- All other logic (registers, edge detect, in-service FSM IDLE/ACTIVE) lives in the top module.

## Test plan

1. Reset, then read all four registers → each reads 0; `HWInt` = 0.
2. MODE = 0x01, MASK = 0x01, pulse `irq_src[0]` for 1 cycle:
   - PEND reads 0x01;
   - `HWInt` = 6'b000001 two edges after the sampled pulse;
   - CUR = 0x8000_0000;
   - EOI write → `HWInt` = 0, PEND = 0.
3. MASK = 0x3F, level sources 1 and 4 both high:
   - `HWInt` = 6'b000010, CUR id = 1.
   - Drop `irq_src[1]` and EOI → `HWInt` = 0 for 1 cycle, then 6'b010000, CUR id = 4.
4. Edge source 2 with MASK = 0:
   - pulse → PEND = 0x04, `HWInt` stays 0.
   - Write PEND = 0x04 on the same edge as a second rising edge → PEND stays 0x04.
   - Write PEND = 0x04 alone → PEND = 0.
5. Source 3 in service, then:
   - write MASK = 0 → `HWInt` stays 6'b001000 until EOI;
   - assert `reset` mid-service → `HWInt` = 0 and all registers 0 after that edge.
